// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small input byte FIFO (valid/ready push side).
// Frames run back to back while the FIFO holds data; TXD and busy come from registers.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        TXD,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic              push_s;
  logic              pop_s;
  logic [7:0]        head_s;

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [BAUD_W-1:0] baud_r;
  logic [BAUD_W-1:0] baud_s;
  logic [2:0]        bit_r;
  logic [2:0]        bit_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_s;
  logic              txd_r;
  logic              txd_s;
  logic              busy_r;
  logic              busy_s;

  assign in_ready   = (cnt_r < DEPTH_C);
  assign push_s     = in_valid && in_ready;
  assign head_s     = mem_r[rd_ptr_r];
  assign TXD        = txd_r;
  assign busy       = busy_r;
  assign fifo_count = cnt_r;

  // Frame sequencer: pops the head in IDLE or on the last STOP cycle.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_s = BAUD_ZERO;
        if (cnt_r != CNT_ZERO) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          state_s = ST_START;
          txd_s   = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          state_s = ST_DATA;
          txd_s   = shift_r[0];
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = BAUD_ZERO;
          if (bit_r == 3'd7) begin
            state_s = ST_STOP;
            txd_s   = 1'b1;
          end else begin
            // shift_r[0] is the bit on the line; expose the next one now
            shift_s = {1'b0, shift_r[7:1]};
            txd_s   = shift_r[1];
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = BAUD_ZERO;
          if (cnt_r != CNT_ZERO) begin
            pop_s   = 1'b1;
            shift_s = head_s;
            state_s = ST_START;
            txd_s   = 1'b0;
          end else begin
            state_s = ST_IDLE;
            txd_s   = 1'b1;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        txd_s   = 1'b1;
      end
    endcase
  end

  // Next occupancy and registered busy flag.
  always_comb begin
    cnt_s = cnt_r;
    case ({push_s, pop_s})
      2'b10:   cnt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_s = cnt_r - CNT_W'(1);
      default: cnt_s = cnt_r;
    endcase
    busy_s = (state_s != ST_IDLE) || (cnt_s != CNT_ZERO);
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control state, pointers and line register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      baud_r   <= BAUD_ZERO;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
      busy_r  <= busy_s;
      cnt_r   <= cnt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

endmodule
